// File: rtl/run_step_ctrl.sv
// Run/step sequencer: one-hot beats T, one RUN pulse per instruction, panel clear of the PC.
// Optional RUN_STEP_BEAT_STEP_EN: STEP advances one beat per event instead of a whole instruction.
module run_step_ctrl #(
  parameter int BEATS      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             CLEAR,
  input  logic             START,
  input  logic             STOP,
  input  logic             STEP,
  input  logic             PCLR,
  input  logic             HLT,
  output logic [BEATS-1:0] T,
  output logic             RUN,
  output logic             PC_CLEARn,
  output logic             BUSY,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] PRE  = BW'(BEATS - 2);

  typedef enum logic [1:0] {S_CLEARING, S_HALT, S_RUNNING, S_STEPPING} state_t;

  state_t           state, state_n;
  logic [BW-1:0]    beat, beat_n;
  logic [3:0]       clr_cnt, clr_n;
  logic             stop_pend, stop_n;
  logic             hlt_q, hlt_n;
  logic [CNT_W-1:0] cnt_n;
  logic [BEATS-1:0] t_n;
  logic             run_n, clrn_n, busy_n, adv;

  // Switch sample plus history, both preset so a switch held through reset is not an edge.
  logic [3:0] sw_q, sw_h, sw_ev;
  logic       pclr_ev, stop_ev, start_ev, step_ev;

  always_ff @(posedge clk or posedge CLEAR) begin
    if (CLEAR) begin
      sw_q <= 4'hF;
      sw_h <= 4'hF;
    end else begin
      sw_h <= sw_q;
      sw_q <= {PCLR, STOP, START, STEP};
    end
  end

  assign sw_ev = sw_q & ~sw_h;
  assign {pclr_ev, stop_ev, start_ev, step_ev} = sw_ev;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    clr_n   = clr_cnt;
    stop_n  = stop_pend;
    hlt_n   = hlt_q;
    cnt_n   = INSTR_CNT;
    t_n     = T;
    run_n   = 1'b0;
    clrn_n  = PC_CLEARn;
    adv     = 1'b0;
    case (state)
      S_CLEARING: begin
        t_n = '0;
        if (clr_cnt <= 4'd1) begin
          state_n = S_HALT;
          clrn_n  = 1'b1;
        end else begin
          clr_n = clr_cnt - 4'd1;
        end
      end
      S_HALT: begin
        t_n = '0;
        if (stop_ev) begin
          state_n = S_HALT;
        end else if (start_ev) begin
          state_n = S_RUNNING;
          beat_n  = '0;
          t_n     = BEATS'(1);
        end else if (step_ev) begin
          state_n = S_STEPPING;
          beat_n  = '0;
          t_n     = BEATS'(1);
        end
      end
      S_RUNNING: begin
        adv = 1'b1;
        if (stop_ev) stop_n = 1'b1;
      end
      S_STEPPING: begin
`ifdef RUN_STEP_BEAT_STEP_EN
        adv = step_ev | start_ev;
        if (start_ev) state_n = S_RUNNING;
`else
        adv = 1'b1;
`endif
      end
      default: state_n = S_CLEARING;
    endcase

    // RUN and the halt decision both follow HLT as seen when the last beat is entered.
    if (adv) begin
      if (beat == LAST) begin
        cnt_n  = INSTR_CNT + CNT_W'(1);
        beat_n = '0;
        if (state_n == S_STEPPING || stop_n || hlt_q) begin
          state_n = S_HALT;
          stop_n  = 1'b0;
          t_n     = '0;
        end else begin
          t_n = BEATS'(1);
        end
      end else begin
        beat_n = beat + BW'(1);
        t_n    = {T[BEATS-2:0], 1'b0};
        if (beat == PRE) begin
          run_n = ~HLT;
          hlt_n = HLT;
        end
      end
    end

    if (pclr_ev) begin
      state_n = S_CLEARING;
      clr_n   = 4'(CLR_CYCLES);
      beat_n  = '0;
      stop_n  = 1'b0;
      hlt_n   = 1'b0;
      cnt_n   = '0;
      t_n     = '0;
      run_n   = 1'b0;
      clrn_n  = 1'b0;
    end

    busy_n = (state_n == S_RUNNING) || (state_n == S_STEPPING);
  end

  always_ff @(posedge clk or posedge CLEAR) begin
    if (CLEAR) begin
      state     <= S_CLEARING;
      beat      <= '0;
      clr_cnt   <= 4'(CLR_CYCLES);
      stop_pend <= 1'b0;
      hlt_q     <= 1'b0;
      INSTR_CNT <= '0;
      T         <= '0;
      RUN       <= 1'b0;
      PC_CLEARn <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      beat      <= beat_n;
      clr_cnt   <= clr_n;
      stop_pend <= stop_n;
      hlt_q     <= hlt_n;
      INSTR_CNT <= cnt_n;
      T         <= t_n;
      RUN       <= run_n;
      PC_CLEARn <= clrn_n;
      BUSY      <= busy_n;
    end
  end

endmodule

// File: tb/tb_run_step_ctrl.sv
// Bench for run_step_ctrl: directed panel sequences with literal checks, then random switch activity
// compared every cycle against an instruction-level model.
module tb_run_step_ctrl;

  localparam int BEATS = 4;
  localparam int CLR_CYCLES = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic CLEAR = 1'b1;
  logic START = 1'b0, STOP = 1'b0, STEP = 1'b0, PCLR = 1'b0, HLT = 1'b0;
  logic [BEATS-1:0] T;
  logic RUN, PC_CLEARn, BUSY;
  logic [CNT_W-1:0] INSTR_CNT;

  run_step_ctrl #(.BEATS(BEATS), .CLR_CYCLES(CLR_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .CLEAR(CLEAR), .START(START), .STOP(STOP), .STEP(STEP), .PCLR(PCLR), .HLT(HLT),
    .T(T), .RUN(RUN), .PC_CLEARn(PC_CLEARn), .BUSY(BUSY), .INSTR_CNT(INSTR_CNT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model: mode, current beat (-1 = idle), countdown and instruction count.
  localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3;
  int m_mode = M_CLR;
  int m_beat = -1;
  int m_clr = CLR_CYCLES;
  int m_cnt = 0;
  bit m_stop = 0, m_hlt = 0, m_run = 0, m_clrn = 0;
  bit [3:0] smp = 4'hF, hist = 4'hF, ev;

  always @(posedge clk or posedge CLEAR) begin
    if (CLEAR) begin
      m_mode = M_CLR; m_beat = -1; m_clr = CLR_CYCLES; m_cnt = 0;
      m_stop = 0; m_hlt = 0; m_run = 0; m_clrn = 0;
      smp = 4'hF; hist = 4'hF;
    end else begin
      ev = smp & ~hist;
      hist = smp;
      smp = {PCLR, STOP, START, STEP};
      m_run = 0;
      if (ev[3]) begin
        m_mode = M_CLR; m_clr = CLR_CYCLES; m_beat = -1; m_cnt = 0; m_stop = 0; m_hlt = 0; m_clrn = 0;
      end else if (m_mode == M_CLR) begin
        m_clr = m_clr - 1;
        if (m_clr == 0) begin m_mode = M_IDLE; m_clrn = 1; end
      end else if (m_mode == M_IDLE) begin
        if (ev[2]) m_mode = M_IDLE;
        else if (ev[1]) begin m_mode = M_RUN; m_beat = 0; end
        else if (ev[0]) begin m_mode = M_STEP; m_beat = 0; end
      end else begin
        if (m_mode == M_RUN && ev[2]) m_stop = 1;
        if (m_beat == BEATS - 1) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (m_mode == M_STEP || m_stop || m_hlt) begin
            m_mode = M_IDLE; m_beat = -1; m_stop = 0;
          end else begin
            m_beat = 0;
          end
        end else begin
          m_beat = m_beat + 1;
          if (m_beat == BEATS - 1) begin m_hlt = HLT; m_run = !HLT; end
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("T", int'(T), (m_beat < 0) ? 0 : (1 << m_beat));
      chk("RUN", int'(RUN), int'(m_run));
      chk("PC_CLEARn", int'(PC_CLEARn), int'(m_clrn));
      chk("BUSY", int'(BUSY), int'(m_mode == M_RUN || m_mode == M_STEP));
      chk("INSTR_CNT", int'(INSTR_CNT), m_cnt);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    // reset held 3 clocks, then PC_CLEARn low for exactly 2 more
    cycles(1);
    chk_en = 1'b1;
    cycles(2);
    CLEAR = 1'b0;
    cycles(1);
    chk("rst_clrn_low", int'(PC_CLEARn), 0);
    cycles(1);
    chk("rst_clrn_high", int'(PC_CLEARn), 1);
    chk("rst_T", int'(T), 0);
    chk("rst_cnt", int'(INSTR_CNT), 0);

    // continuous run
    START = 1'b1;
    cycles(2);
    chk("run_T0", int'(T), 1);
    cycles(1);
    chk("run_T1", int'(T), 2);
    START = 1'b0;
    cycles(2);
    chk("run_T3", int'(T), 8);
    chk("run_pulse", int'(RUN), 1);
    cycles(17);
    chk("run_cnt5", int'(INSTR_CNT), 5);
    chk("model_cnt5", m_cnt, 5);

    // stop mid-instruction: current instruction completes with RUN
    STOP = 1'b1;
    cycles(3);
    chk("stop_last_run", int'(RUN), 1);
    cycles(1);
    chk("stop_busy", int'(BUSY), 0);
    chk("stop_cnt", int'(INSTR_CNT), 6);
    STOP = 1'b0;

    // single step
    STEP = 1'b1;
    cycles(2);
    chk("step_T0", int'(T), 1);
    STEP = 1'b0;
    cycles(3);
    chk("step_run", int'(RUN), 1);
    cycles(1);
    chk("step_halt", int'(BUSY), 0);
    chk("step_cnt", int'(INSTR_CNT), 7);

    // programmed halt suppresses RUN but still counts
    HLT = 1'b1;
    START = 1'b1;
    cycles(2);
    START = 1'b0;
    cycles(3);
    chk("hlt_T3", int'(T), 8);
    chk("hlt_norun", int'(RUN), 0);
    cycles(1);
    chk("hlt_busy", int'(BUSY), 0);
    chk("hlt_cnt", int'(INSTR_CNT), 8);
    HLT = 1'b0;

    // panel clear during T2
    START = 1'b1;
    cycles(3);
    START = 1'b0;
    PCLR = 1'b1;
    cycles(1);
    chk("abort_T2", int'(T), 4);
    cycles(1);
    chk("abort_T", int'(T), 0);
    chk("abort_run", int'(RUN), 0);
    chk("abort_cnt", int'(INSTR_CNT), 0);
    PCLR = 1'b0;
    cycles(1);
    chk("abort_clrn", int'(PC_CLEARn), 0);
    cycles(1);
    chk("abort_clrn_done", int'(PC_CLEARn), 1);

    // START and STOP together in HALT: STOP wins
    START = 1'b1;
    STOP = 1'b1;
    cycles(3);
    chk("ss_busy", int'(BUSY), 0);
    START = 1'b0;
    STOP = 1'b0;
    cycles(2);

    // counter wrap at 2^CNT_W
    START = 1'b1;
    cycles(2);
    START = 1'b0;
    cycles(68);
    chk("wrap_cnt", int'(INSTR_CNT), 1);
    chk("model_wrap", m_cnt, 1);
    STOP = 1'b1;
    cycles(4);
    chk("wrap_stop", int'(BUSY), 0);
    STOP = 1'b0;

    // START held through reset is not an edge
    START = 1'b1;
    cycles(1);
    CLEAR = 1'b1;
    cycles(2);
    CLEAR = 1'b0;
    cycles(6);
    chk("held_no_run", int'(BUSY), 0);
    START = 1'b0;
    cycles(1);
    START = 1'b1;
    cycles(2);
    chk("fresh_edge_T0", int'(T), 1);
    START = 1'b0;
    PCLR = 1'b1;
    cycles(3);
    PCLR = 1'b0;
    cycles(4);

    // random switch activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) START = ~START;
      if ($urandom_range(0, 11) == 0) STOP = ~STOP;
      if ($urandom_range(0, 7) == 0) STEP = ~STEP;
      if ($urandom_range(0, 59) == 0) PCLR = ~PCLR;
      if ($urandom_range(0, 3) == 0) HLT = ~HLT;
      CLEAR = ($urandom_range(0, 799) == 0);
      cycles(1);
    end
    CLEAR = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
